pipe_ctrl: RTL and testbench

- Central pipeline controller for the 3-stage core (pc_reg → if_id → id_ex → ex).
- Sequences branch redirects, multi-cycle ex holds, external bus-master grants and debug halts.
- Turns them into per-stage stall, flush and bubble controls.
- Arbitrates between these sources with fixed priority, and guarantees that no instruction is lost or executed twice.

---
 rtl/pipe_ctrl_if.sv | 37 +++
 rtl/pipe_ctrl.sv | 157 +++++++++++++++
 tb/tb_pipe_ctrl.sv | 133 +++++++++++++
 3 files changed

// File: rtl/pipe_ctrl_if.sv
// Pipeline-control bundle between the core stages and pipe_ctrl; slave = controller, master = core side.
// Statistics outputs exist only when PIPE_CTRL_STAT_EN is defined.
interface pipe_ctrl_if;
  logic        jump_en_i;
  logic [31:0] jump_addr_i;
  logic        hold_flag_i;
  logic        bus_req_i;
  logic        halt_req_i;
  logic        jump_en_o;
  logic [31:0] jump_addr_o;
  logic [2:0]  stall_o;
  logic        flush_o;
  logic        bubble_o;
  logic        bus_gnt_o;
  logic        halted_o;
`ifdef PIPE_CTRL_STAT_EN
  logic [31:0] stall_cnt_o;
  logic [31:0] flush_cnt_o;
  logic [15:0] gnt_cnt_o;
`endif

  modport slave (
    input  jump_en_i, jump_addr_i, hold_flag_i, bus_req_i, halt_req_i,
    output jump_en_o, jump_addr_o, stall_o, flush_o, bubble_o, bus_gnt_o, halted_o
`ifdef PIPE_CTRL_STAT_EN
    , output stall_cnt_o, flush_cnt_o, gnt_cnt_o
`endif
  );

  modport master (
    output jump_en_i, jump_addr_i, hold_flag_i, bus_req_i, halt_req_i,
    input  jump_en_o, jump_addr_o, stall_o, flush_o, bubble_o, bus_gnt_o, halted_o
`ifdef PIPE_CTRL_STAT_EN
    , input stall_cnt_o, flush_cnt_o, gnt_cnt_o
`endif
  );
endinterface

// File: rtl/pipe_ctrl.sv
// Pipeline controller: fixed-priority jump > hold > bus grant > halt, producing stall/flush/bubble controls.
// Redirect and hold stalls are combinational in the request cycle; grant/halt take effect the next cycle. Optional stats: PIPE_CTRL_STAT_EN.
module pipe_ctrl #(
  parameter int FLUSH_CYCLES   = 1,
  parameter int BUS_MAX_CYCLES = 16
) (
  input  logic         clk,
  input  logic         rst,
  pipe_ctrl_if.slave   ctl
);

  typedef enum logic [2:0] {RUN, FLUSH, EX_HOLD, BUS_GNT, HALT} state_t;

  localparam logic [2:0] FLUSH_LOAD = 3'(FLUSH_CYCLES - 1);
  localparam logic [7:0] GNT_LAST   = 8'(BUS_MAX_CYCLES - 1);

  state_t      state, state_nxt;
  logic [2:0]  flush_cnt, flush_cnt_nxt;
  logic [7:0]  gnt_cnt, gnt_cnt_nxt;
  logic        cooldown, cooldown_nxt;
  logic        ret_halt, ret_halt_nxt;
  logic        forced_rel;

  logic        jump_en;
  logic [31:0] jump_addr;
  logic [2:0]  stall;
  logic        flush, bubble, bus_gnt, halted;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= RUN;
      flush_cnt <= '0;
      gnt_cnt   <= '0;
      cooldown  <= 1'b0;
      ret_halt  <= 1'b0;
    end else begin
      state     <= state_nxt;
      flush_cnt <= flush_cnt_nxt;
      gnt_cnt   <= gnt_cnt_nxt;
      cooldown  <= cooldown_nxt;
      ret_halt  <= ret_halt_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    flush_cnt_nxt = flush_cnt;
    gnt_cnt_nxt   = gnt_cnt;
    cooldown_nxt  = 1'b0;
    ret_halt_nxt  = ret_halt;
    forced_rel    = 1'b0;
    jump_en       = 1'b0;
    jump_addr     = '0;
    stall         = 3'b000;
    flush         = 1'b0;
    bubble        = 1'b0;
    bus_gnt       = 1'b0;
    halted        = 1'b0;
    case (state)
      RUN: begin
        if (ctl.jump_en_i) begin
          jump_en   = 1'b1;
          jump_addr = ctl.jump_addr_i;
          flush     = 1'b1;
          if (FLUSH_CYCLES > 1) begin
            state_nxt     = FLUSH;
            flush_cnt_nxt = FLUSH_LOAD;
          end
        end else if (ctl.hold_flag_i) begin
          stall     = 3'b111;
          state_nxt = EX_HOLD;
        end else if (ctl.bus_req_i && !cooldown) begin
          state_nxt    = BUS_GNT;
          gnt_cnt_nxt  = '0;
          ret_halt_nxt = 1'b0;
        end else if (ctl.halt_req_i) begin
          state_nxt = HALT;
        end
      end
      FLUSH: begin
        flush = 1'b1;
        if (flush_cnt <= 3'd1) begin
          state_nxt     = RUN;
          flush_cnt_nxt = '0;
        end else begin
          flush_cnt_nxt = flush_cnt - 3'd1;
        end
      end
      EX_HOLD: begin
        // Hold release is seen combinationally so ex advances the same cycle.
        if (ctl.hold_flag_i) stall = 3'b111;
        else                 state_nxt = RUN;
      end
      BUS_GNT: begin
        bus_gnt = 1'b1;
        stall   = 3'b011;
        bubble  = 1'b1;
        if (!ctl.bus_req_i || gnt_cnt == GNT_LAST) begin
          forced_rel  = ctl.bus_req_i;
          gnt_cnt_nxt = '0;
          if (ret_halt && ctl.halt_req_i) begin
            state_nxt = HALT;
          end else begin
            state_nxt    = RUN;
            cooldown_nxt = 1'b1;
          end
        end else begin
          gnt_cnt_nxt = gnt_cnt + 8'd1;
        end
      end
      HALT: begin
        halted = 1'b1;
        stall  = 3'b011;
        bubble = 1'b1;
        if (ctl.bus_req_i) begin
          state_nxt    = BUS_GNT;
          gnt_cnt_nxt  = '0;
          ret_halt_nxt = 1'b1;
        end else if (!ctl.halt_req_i) begin
          state_nxt = RUN;
        end
      end
      default: state_nxt = RUN;
    endcase
  end

  // Everything is forced quiet while reset is asserted, including the first cycle.
  assign ctl.jump_en_o   = rst & jump_en;
  assign ctl.jump_addr_o = {32{rst}} & jump_addr;
  assign ctl.stall_o     = {3{rst}} & stall;
  assign ctl.flush_o     = rst & flush;
  assign ctl.bubble_o    = rst & bubble;
  assign ctl.bus_gnt_o   = rst & bus_gnt;
  assign ctl.halted_o    = rst & halted;

`ifdef PIPE_CTRL_STAT_EN
  logic [31:0] stall_cnt, flush_cnt_stat;
  logic [15:0] gnt_cnt_stat;

  always_ff @(posedge clk) begin
    if (!rst) begin
      stall_cnt      <= '0;
      flush_cnt_stat <= '0;
      gnt_cnt_stat   <= '0;
    end else begin
      if (|stall && stall_cnt != '1)          stall_cnt      <= stall_cnt + 32'd1;
      if (jump_en && flush_cnt_stat != '1)    flush_cnt_stat <= flush_cnt_stat + 32'd1;
      if (forced_rel && gnt_cnt_stat != '1)   gnt_cnt_stat   <= gnt_cnt_stat + 16'd1;
    end
  end

  assign ctl.stall_cnt_o = stall_cnt;
  assign ctl.flush_cnt_o = flush_cnt_stat;
  assign ctl.gnt_cnt_o   = gnt_cnt_stat;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl with FLUSH_CYCLES=2, BUS_MAX_CYCLES=4.
// Inputs change 1ns after posedge; outputs are checked at the following negedge.
module tb_pipe_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   errors = 0;

  pipe_ctrl_if ifc ();

  pipe_ctrl #(.FLUSH_CYCLES(2), .BUS_MAX_CYCLES(4)) dut (
    .clk (clk),
    .rst (rst),
    .ctl (ifc)
  );

  always #5 clk = ~clk;

  // {jump_en, flush, stall[2:0], bubble, bus_gnt, halted}
  wire [7:0] outs = {ifc.jump_en_o, ifc.flush_o, ifc.stall_o, ifc.bubble_o, ifc.bus_gnt_o, ifc.halted_o};

  localparam logic [7:0] O_IDLE = 8'b0_0_000_0_0_0;
  localparam logic [7:0] O_GNT  = 8'b0_0_011_1_1_0;
  localparam logic [7:0] O_HALT = 8'b0_0_011_1_0_1;
  localparam logic [7:0] O_HOLD = 8'b0_0_111_0_0_0;
  localparam logic [7:0] O_JMP  = 8'b1_1_000_0_0_0;
  localparam logic [7:0] O_FL   = 8'b0_1_000_0_0_0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    ifc.jump_en_i   = 1'b0;
    ifc.jump_addr_i = 32'h0;
    ifc.hold_flag_i = 1'b0;
    ifc.bus_req_i   = 1'b1;
    ifc.halt_req_i  = 1'b1;

    // Reset held three edges with bus and halt requests pending
    for (int i = 0; i < 3; i++) begin
      smp();
      chk("rst_outs", {24'h0, outs}, {24'h0, O_IDLE});
      chk("rst_addr", ifc.jump_addr_o, 32'h0);
    end
    rst = 1'b1;
    ifc.halt_req_i = 1'b0;
    #1 chk("rel_no_gnt", {24'h0, outs}, {24'h0, O_IDLE});

    // Forced release after 4 grant cycles, one cooldown cycle, then re-grant
    for (int i = 0; i < 4; i++) begin
      nxt(); smp(); chk("gnt_forced", {24'h0, outs}, {24'h0, O_GNT});
    end
    nxt(); smp(); chk("gnt_cooldown", {24'h0, outs}, {24'h0, O_IDLE});
    nxt(); smp(); chk("gnt_rearb", {24'h0, outs}, {24'h0, O_IDLE});
    nxt(); ifc.bus_req_i = 1'b0; smp(); chk("gnt_again", {24'h0, outs}, {24'h0, O_GNT});
    nxt(); smp(); chk("gnt_drop", {24'h0, outs}, {24'h0, O_IDLE});

    // Jump: two flush cycles, jump_en_i ignored while flushing
    nxt(); ifc.jump_en_i = 1'b1; ifc.jump_addr_i = 32'h0000_0040; smp();
    chk("jmp_outs", {24'h0, outs}, {24'h0, O_JMP});
    chk("jmp_addr", ifc.jump_addr_o, 32'h0000_0040);
    nxt(); ifc.jump_addr_i = 32'h0000_1234; smp();
    chk("flush2_outs", {24'h0, outs}, {24'h0, O_FL});
    chk("flush2_addr", ifc.jump_addr_o, 32'h0);
    nxt(); ifc.jump_en_i = 1'b0; smp();
    chk("flush_done", {24'h0, outs}, {24'h0, O_IDLE});

    // EX hold for 4 cycles, bus request raised mid-hold
    nxt(); ifc.hold_flag_i = 1'b1; smp(); chk("hold1", {24'h0, outs}, {24'h0, O_HOLD});
    nxt(); ifc.bus_req_i = 1'b1; smp(); chk("hold2", {24'h0, outs}, {24'h0, O_HOLD});
    nxt(); smp(); chk("hold3", {24'h0, outs}, {24'h0, O_HOLD});
    nxt(); smp(); chk("hold4", {24'h0, outs}, {24'h0, O_HOLD});
    nxt(); ifc.hold_flag_i = 1'b0; smp(); chk("hold_end", {24'h0, outs}, {24'h0, O_IDLE});
    nxt(); smp(); chk("hold_bus_arb", {24'h0, outs}, {24'h0, O_IDLE});
    nxt(); ifc.bus_req_i = 1'b0; smp(); chk("hold_bus_gnt", {24'h0, outs}, {24'h0, O_GNT});
    nxt(); smp(); chk("hold_bus_rel", {24'h0, outs}, {24'h0, O_IDLE});

    // Simultaneous jump + hold + bus: jump, flush, hold, then grant
    nxt(); ifc.jump_en_i = 1'b1; ifc.hold_flag_i = 1'b1; ifc.bus_req_i = 1'b1;
    ifc.jump_addr_i = 32'h0000_0080; smp();
    chk("sim_jmp", {24'h0, outs}, {24'h0, O_JMP});
    chk("sim_addr", ifc.jump_addr_o, 32'h0000_0080);
    nxt(); ifc.jump_en_i = 1'b0; smp(); chk("sim_flush", {24'h0, outs}, {24'h0, O_FL});
    nxt(); smp(); chk("sim_hold", {24'h0, outs}, {24'h0, O_HOLD});
    nxt(); ifc.hold_flag_i = 1'b0; smp(); chk("sim_hold_end", {24'h0, outs}, {24'h0, O_IDLE});
    nxt(); smp(); chk("sim_bus_arb", {24'h0, outs}, {24'h0, O_IDLE});
    nxt(); ifc.bus_req_i = 1'b0; smp(); chk("sim_bus_gnt", {24'h0, outs}, {24'h0, O_GNT});
    nxt(); smp(); chk("sim_bus_rel", {24'h0, outs}, {24'h0, O_IDLE});

    // Halt with a 3-cycle bus pulse, back to HALT, then release
    nxt(); ifc.halt_req_i = 1'b1; smp(); chk("halt_req", {24'h0, outs}, {24'h0, O_IDLE});
    nxt(); ifc.jump_en_i = 1'b1; ifc.jump_addr_i = 32'h0000_0099; smp();
    chk("halt_on", {24'h0, outs}, {24'h0, O_HALT});
    chk("halt_jmp_addr", ifc.jump_addr_o, 32'h0);
    nxt(); ifc.jump_en_i = 1'b0; ifc.bus_req_i = 1'b1; smp();
    chk("halt_bus_arb", {24'h0, outs}, {24'h0, O_HALT});
    nxt(); smp(); chk("halt_gnt1", {24'h0, outs}, {24'h0, O_GNT});
    nxt(); smp(); chk("halt_gnt2", {24'h0, outs}, {24'h0, O_GNT});
    nxt(); ifc.bus_req_i = 1'b0; smp(); chk("halt_gnt3", {24'h0, outs}, {24'h0, O_GNT});
    nxt(); smp(); chk("halt_back", {24'h0, outs}, {24'h0, O_HALT});
    nxt(); ifc.halt_req_i = 1'b0; smp(); chk("halt_rel", {24'h0, outs}, {24'h0, O_HALT});
    nxt(); smp(); chk("halt_exit", {24'h0, outs}, {24'h0, O_IDLE});

    // Reset in the middle of a grant abandons it
    nxt(); ifc.bus_req_i = 1'b1; smp(); chk("mid_arb", {24'h0, outs}, {24'h0, O_IDLE});
    nxt(); smp(); chk("mid_gnt", {24'h0, outs}, {24'h0, O_GNT});
    nxt(); rst = 1'b0; smp(); chk("mid_rst", {24'h0, outs}, {24'h0, O_IDLE});
    nxt(); rst = 1'b1; ifc.bus_req_i = 1'b0; smp(); chk("mid_after", {24'h0, outs}, {24'h0, O_IDLE});

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
